// File: rtl/dmi_access_ctrl_pkg.sv
// Shared DMI types (dm) and the access controller's private FSM encoding.
// The optional response-timeout abort is enabled by defining DMI_RESP_TIMEOUT_EN.
package dm;
    localparam int unsigned DMI_ADDR_W = 7;
    localparam int unsigned DMI_DATA_W = 32;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DMI_OK     = 2'd0,
        DMI_FAILED = 2'd2,
        DMI_BUSY   = 2'd3
    } dmi_status_e;

    typedef struct packed {
        logic [DMI_ADDR_W-1:0] addr;
        dtm_op_e               op;
        logic [DMI_DATA_W-1:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [DMI_DATA_W-1:0] data;
        logic [1:0]            resp;
    } dmi_resp_t;
endpackage

package dmi_access_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_READ,
        WRITE,
        WAIT_WRITE
    } state_e;

    function automatic logic is_wait(input state_e s);
        return (s == WAIT_READ) || (s == WAIT_WRITE);
    endfunction
endpackage

// File: rtl/dmi_access_ctrl_if.sv
// DMI request/response bus between the access controller (master) and the CDC stage (slave).
interface dmi_access_ctrl_if;
    import dm::*;

    dmi_req_t  dmi_req_o;
    logic      dmi_req_valid_o;
    logic      dmi_req_ready_i;
    dmi_resp_t dmi_resp_i;
    logic      dmi_resp_valid_i;
    logic      dmi_resp_ready_o;
    logic      dmi_clear_o;

    modport master (
        output dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o, dmi_clear_o,
        input  dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i
    );

    modport slave (
        input  dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o, dmi_clear_o,
        output dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i
    );
endinterface

// File: rtl/dmi_access_ctrl.sv
// DTM-side DMI access controller: JTAG DR updates -> DMI req/resp, sticky status.
// Define DMI_RESP_TIMEOUT_EN to abort WAIT states after TIMEOUT_CYCLES without a response.
module dmi_access_ctrl
    import dm::*;
    import dmi_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W         = 7,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              update_i,
    input  logic              capture_i,
    input  logic [1:0]        dr_op_i,
    input  logic [ADDR_W-1:0] dr_addr_i,
    input  logic [DATA_W-1:0] dr_data_i,
    input  logic              dmireset_i,
    input  logic              dmihardreset_i,
    output logic [ADDR_W-1:0] dr_addr_o,
    output logic [DATA_W-1:0] dr_data_o,
    output logic [1:0]        dr_status_o,
    dmi_access_ctrl_if.master dmi
);

    if (ADDR_W != DMI_ADDR_W) begin : g_addr_w_chk
        $error("ADDR_W must match dm::dmi_req_t addr width");
    end
    if (DATA_W != DMI_DATA_W) begin : g_data_w_chk
        $error("DATA_W must match dm data width");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    dmi_status_e       error_q, error_d;
    logic              clear_q, clear_d;
    logic              timeout;
    logic              resp_err;
    dmi_req_t          req;
    logic              req_valid;
    logic              resp_ready;

`ifdef DMI_RESP_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // Zero in the first WAIT cycle, so the abort fires on the TIMEOUT_CYCLES-th wait cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (is_wait(state_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout = is_wait(state_q) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        error_d    = error_q;
        clear_d    = 1'b0;
        resp_err   = 1'b0;
        req        = '0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (update_i && (error_q == DMI_OK)) begin
                    if (dr_op_i == DTM_READ) begin
                        addr_d  = dr_addr_i;
                        state_d = READ;
                    end else if (dr_op_i == DTM_WRITE) begin
                        addr_d  = dr_addr_i;
                        data_d  = dr_data_i;
                        state_d = WRITE;
                    end
                end
            end
            READ, WRITE: begin
                req_valid = 1'b1;
                req.addr  = addr_q;
                req.op    = (state_q == READ) ? DTM_READ : DTM_WRITE;
                req.data  = (state_q == READ) ? '0 : data_q;
                if (dmi.dmi_req_ready_i) begin
                    state_d = (state_q == READ) ? WAIT_READ : WAIT_WRITE;
                end
            end
            WAIT_READ, WAIT_WRITE: begin
                resp_ready = 1'b1;
                if (dmi.dmi_resp_valid_i) begin
                    state_d = IDLE;
                    if (state_q == WAIT_READ) begin
                        data_d = dmi.dmi_resp_i.data;
                    end
                    resp_err = (dmi.dmi_resp_i.resp != 2'b00);
                end else if (timeout) begin
                    state_d  = IDLE;
                    resp_err = 1'b1;
                    clear_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // First error wins; a failed access outranks a same-cycle busy.
        if (error_q == DMI_OK) begin
            if (resp_err) begin
                error_d = DMI_FAILED;
            end else if ((update_i || capture_i) && (state_q != IDLE)) begin
                error_d = DMI_BUSY;
            end
        end

        if (dmihardreset_i) begin
            state_d = IDLE;
            data_d  = data_q;
            error_d = DMI_OK;
            clear_d = 1'b1;
        end
        if (dmireset_i) begin
            error_d = DMI_OK;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            error_q <= DMI_OK;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            error_q <= error_d;
            clear_q <= clear_d;
        end
    end

    assign dr_addr_o            = addr_q;
    assign dr_data_o            = data_q;
    assign dr_status_o          = error_q;
    assign dmi.dmi_req_o        = req;
    assign dmi.dmi_req_valid_o  = req_valid;
    assign dmi.dmi_resp_ready_o = resp_ready;
    assign dmi.dmi_clear_o      = clear_q;

endmodule

// File: doc/dmi_access_ctrl.md
Name: dmi_access_ctrl

Overview:
- DTM-side DMI access controller, directly upstream of the DMI CDC stage.
- Turns JTAG DMI data-register updates (op/addr/data) into dm::dmi_req_t valid/ready transactions.
- Collects dm::dmi_resp_t responses and keeps the sticky DMI status the TAP shifts back out.
- Drives dmi_clear_o toward the CDC stage on a DMI hard reset.

Parameters:
- ADDR_W, 7, DMI address width; must match dm::dmi_req_t addr field.
- DATA_W, 32, DMI data width; must match dm package data fields.
- TIMEOUT_CYCLES, 1024, wait-state abort limit; used only with DMI_RESP_TIMEOUT_EN; minimum 2.

Ports:
- clk_i  in  1  clock (TCK domain)
- rst_ni  in  1  reset, asynchronous, active-low
- update_i  in  1  one-cycle pulse: DMI DR update
- capture_i  in  1  one-cycle pulse: DMI DR capture
- dr_op_i  in  2  op field of the shifted DR: 0 nop, 1 read, 2 write, 3 reserved
- dr_addr_i  in  ADDR_W  address field of the shifted DR
- dr_data_i  in  DATA_W  data field of the shifted DR
- dmireset_i  in  1  clear sticky error (dtmcs.dmireset)
- dmihardreset_i  in  1  abort access and clear (dtmcs.dmihardreset)
- dr_addr_o  out  ADDR_W  last latched address, for capture
- dr_data_o  out  DATA_W  last read data, for capture
- dr_status_o  out  2  sticky status: 0 ok, 2 failed, 3 busy
- dmi_clear_o  out  1  clear pulse to the CDC stage
- dmi_req_o  out  dm::dmi_req_t  request
- dmi_req_valid_o  out  1  request valid
- dmi_req_ready_i  in  1  request ready
- dmi_resp_i  in  dm::dmi_resp_t  response
- dmi_resp_valid_i  in  1  response valid
- dmi_resp_ready_o  out  1  response ready

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state IDLE; all outputs 0.
  - Internal addr_q, data_q and error_q are 0.
- FSM states: IDLE, READ, WAIT_READ, WRITE, WAIT_WRITE.
- IDLE:
  - update_i with error_q == 0 and op 1: latch addr, go to READ.
  - update_i with error_q == 0 and op 2: latch addr and data, go to WRITE.
  - op 0 or op 3: stay in IDLE, no request issued.
  - If error_q != 0 (registered value), update_i is ignored entirely.
- READ / WRITE:
  - dmi_req_valid_o = 1.
  - dmi_req_o.op = DTM_READ or DTM_WRITE; dmi_req_o.addr = addr_q.
  - dmi_req_o.data = data_q for writes, 0 for reads.
  - Valid and payload are held stable until dmi_req_ready_i.
  - On the handshake, go to WAIT_READ or WAIT_WRITE.
- Latency: update_i in cycle N gives dmi_req_valid_o high in cycle N+1.
- WAIT_READ / WAIT_WRITE:
  - dmi_resp_ready_o = 1 (0 in all other states).
  - On dmi_resp_valid_i, return to IDLE next cycle.
  - WAIT_READ additionally latches data_q <= dmi_resp_i.data.
  - dmi_resp_i.resp != 0 sets error_q = 2, only if error_q == 0.
- Busy detection:
  - update_i or capture_i while state != IDLE sets error_q = 3, only if error_q == 0.
  - The new request is dropped; the in-flight access continues.
- Sticky error: the first error wins; it is never overwritten until cleared.
- dmireset_i:
  - error_q <= 0; this takes priority over any same-cycle error set.
  - No effect on the FSM.
- dmihardreset_i:
  - FSM to IDLE; error_q <= 0; dmi_req_valid_o drops next cycle.
  - dmi_clear_o = 1 for exactly one cycle.
  - Any in-flight response is discarded.
  - Takes priority over all other inputs in the same cycle.
- dr_addr_o, dr_data_o and dr_status_o are always driven from addr_q, data_q and error_q.
- capture_i has no other effect.
- Response during READ/WRITE (before request accept) cannot occur; it is ignored.

Optional Feature:
- Macro DMI_RESP_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in the WAIT states.
  - It resets to 0 on entering a WAIT state.
  - When it reaches TIMEOUT_CYCLES-1 with no response: error_q = 2 (if 0), FSM to IDLE, dmi_clear_o pulses one cycle.
- Undefined: no counter; WAIT states hold indefinitely.

Decomposition:
- Shared dm package:
  - dtm_op_e (NOP / READ / WRITE), dmi_status_e (OK=0 / FAILED=2 / BUSY=3).
  - dmi_req_t and dmi_resp_t.
- No sub-module; the timeout counter stays inline.

Test Plan:
- Write: update op=2, addr=0x10, data=0xDEADBEEF, ready held high.
  - Required: valid one cycle after update; payload {0x10, WRITE, 0xDEADBEEF}.
  - Required: resp {resp=0} returns to IDLE; status 0.
- Read: update op=1, addr=0x11; ready delayed 3 cycles; resp data=0x12345678.
  - Required: valid held stable 4 cycles; dr_data_o=0x12345678; status 0.
- Busy: second update arrives during WAIT_READ.
  - Required: status 3; second request never issued.
  - Required: subsequent update ignored until dmireset_i, after which a read succeeds.
- Failed: resp.resp=2 on a write.
  - Required: status 2; a later busy does not change it to 3.
- Hard reset in WAIT_WRITE.
  - Required: dmi_clear_o one-cycle pulse; valid 0; status 0; FSM IDLE.
- With DMI_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response.
  - Required: return to IDLE after 8 wait cycles; status 2; dmi_clear_o pulse.
